// File: rtl/neg_mult_pkg.sv
// Shared constants and the magnitude helper for the sign-magnitude multiplier.
package neg_mult_pkg;

    localparam int AW_DEF   = 27;
    localparam int BW_DEF   = 24;
    localparam int LATENCY  = 4;
    localparam int ABS_MAXW = 64;

    // Callers sign-extend to ABS_MAXW and keep the low W bits; for W < ABS_MAXW
    // the most-negative W-bit value yields 2^(W-1) without overflow.
    function automatic logic [ABS_MAXW-1:0] abs_u(input logic signed [ABS_MAXW-1:0] value);
        return value[ABS_MAXW-1] ? ABS_MAXW'(-value) : ABS_MAXW'(value);
    endfunction

endpackage

// File: rtl/neg_mult_abs.sv
// Splits a W-bit two's-complement value into an unsigned W-bit magnitude and a sign bit.
module neg_mult_abs
    import neg_mult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic signed [W-1:0] i_val,
    output logic        [W-1:0] o_mag,
    output logic                o_sign
);

    logic signed [ABS_MAXW-1:0]   w_ext;
    logic        [ABS_MAXW-1:0]   w_abs;
    logic        [ABS_MAXW-W-1:0] w_hi_unused;

    assign w_ext                = ABS_MAXW'(i_val);
    assign w_abs                = abs_u(w_ext);
    assign {w_hi_unused, o_mag} = w_abs;
    assign o_sign               = i_val[W-1];

endmodule

// File: rtl/neg_mult.sv
// Four-stage pipelined signed multiplier: register, abs/sign, unsigned multiply, conditional negate.
module neg_mult
    import neg_mult_pkg::*;
#(
    parameter  int AW = AW_DEF,
    parameter  int BW = BW_DEF,
    localparam int MW = AW + BW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [AW-1:0] ain,
    input  logic signed [BW-1:0] bin,
    output logic signed [MW-1:0] prod
);

    logic [AW-1:0] r_a;
    logic [BW-1:0] r_b;
    logic [AW-1:0] w_mag_a;
    logic [BW-1:0] w_mag_b;
    logic          w_sign_a;
    logic          w_sign_b;
    logic [AW-1:0] r_mag_a;
    logic [BW-1:0] r_mag_b;
    logic          r_sign_s2;
    logic [MW-1:0] w_mag_p;
    logic [MW-1:0] r_mag_p;
    logic          r_sign_s3;
    logic [MW-1:0] w_neg_p;
    logic [MW-1:0] r_prod;

    neg_mult_abs #(.W(AW)) u_abs_a (
        .i_val  (r_a),
        .o_mag  (w_mag_a),
        .o_sign (w_sign_a)
    );

    neg_mult_abs #(.W(BW)) u_abs_b (
        .i_val  (r_b),
        .o_mag  (w_mag_b),
        .o_sign (w_sign_b)
    );

    assign w_mag_p = MW'(r_mag_a) * MW'(r_mag_b);
    // Two's-complement negation of a zero magnitude is zero, so sign=1 with mag=0 stays 0.
    assign w_neg_p = -r_mag_p;

    // NOTE: every pipeline stage resets to 0 asynchronously so an in-flight
    // result can never leak out after rst_n is asserted; non-blocking
    // assignments keep the stages shifting in lock-step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_sign_s2 <= 1'b0;
            r_mag_p   <= '0;
            r_sign_s3 <= 1'b0;
            r_prod    <= '0;
        end else begin
            r_a       <= ain;
            r_b       <= bin;
            r_mag_a   <= w_mag_a;
            r_mag_b   <= w_mag_b;
            r_sign_s2 <= w_sign_a ^ w_sign_b;
            r_mag_p   <= w_mag_p;
            r_sign_s3 <= r_sign_s2;
            r_prod    <= r_sign_s3 ? w_neg_p : r_mag_p;
        end
    end

    assign prod = r_prod;

endmodule

// File: tb/tb_neg_mult.sv
// Randomised and directed checks of neg_mult against a latency-queue model of ain*bin.
module tb_neg_mult;
    import neg_mult_pkg::*;

    localparam int AW = AW_DEF;
    localparam int BW = BW_DEF;
    localparam int MW = AW + BW;

    logic                 clk;
    logic                 rst_n;
    logic signed [AW-1:0] ain;
    logic signed [BW-1:0] bin;
    logic signed [MW-1:0] prod;

    int     n_checks;
    int     n_pass;
    longint exp_q[$];

    neg_mult #(.AW(AW), .BW(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ain   (ain),
        .bin   (bin),
        .prod  (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // After reset the pipe holds zeros, so the first LATENCY-1 outputs are 0.
    task automatic flush_model();
        exp_q.delete();
        for (int i = 0; i < LATENCY - 1; i++) exp_q.push_back(0);
    endtask

    // Drives one operand pair now, then checks prod just after the next edge.
    task automatic step(input string tag, input longint a, input longint b);
        longint e;
        ain = AW'(a);
        bin = BW'(b);
        exp_q.push_back(a * b);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, longint'(prod), e);
    endtask

    initial begin
        longint a;
        longint b;
        n_checks = 0;
        n_pass   = 0;

        rst_n = 1'b0;
        ain   = AW'(5);
        bin   = BW'(-3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", longint'(prod), 0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        flush_model();
        step("reset_first", 5, -3);
        for (int i = 0; i < 3; i++) step("reset_first", 0, 0);

        step("quadrant", 7, 6);
        step("quadrant", -7, 6);
        step("quadrant", 7, -6);
        step("quadrant", -7, -6);

        step("zero_sign", 0, -10);
        step("zero_sign", -10, 0);
        step("zero_sign", -1, 1);

        step("extreme", -(64'sd1 << 26), -(64'sd1 << 23));
        step("extreme", -(64'sd1 << 26), (64'sd1 << 23) - 1);
        step("extreme", (64'sd1 << 26) - 1, (64'sd1 << 23) - 1);
        step("extreme", (64'sd1 << 26) - 1, -(64'sd1 << 23));

        for (int i = 0; i < 12; i++) begin
            a = longint'($urandom_range(20)) - 10;
            b = longint'($urandom_range(20)) - 10;
            step("random", a, b);
        end
        for (int i = 0; i < LATENCY; i++) step("drain", 0, 0);

        // Nonzero pairs so both the visible output and the in-flight stages are nonzero.
        for (int i = 0; i < 6; i++) begin
            a = longint'($urandom_range(9)) + 1;
            b = -(longint'($urandom_range(9)) + 1);
            step("pre_reset", a, b);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", longint'(prod), 0);
        ain = '0;
        bin = '0;
        @(posedge clk);
        #1;
        check("reset_mid_hold", longint'(prod), 0);
        @(negedge clk);
        rst_n = 1'b1;
        flush_model();
        for (int i = 0; i < LATENCY; i++) step("post_reset", 0, 0);
        step("post_reset", 9, -9);
        for (int i = 0; i < LATENCY; i++) step("post_reset", 3, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
